sync_tx_fifo: RTL and testbench

- Transmit-side feeder for sync_multi, in the clk_tx domain.
- Buffers words from the core in a small FIFO.
- Presents the words one at a time on sync_multi's in_data/v inputs using the 4-phase req/ack protocol, with f as the acknowledge returned from the rx side.
- Lets the core write bursts without tracking the slow crossing handshake.

---
 rtl/sync_tx_fifo_pkg.sv | 19 +
 rtl/sync_tx_fifo_mem.sv | 76 +++++++
 rtl/sync_tx_fifo.sv | 91 +++++++++
 tb/tb_sync_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_tx_fifo_pkg.sv
// Shared definitions for the transmit-side FIFO feeder: handshake state
// encodings and default geometry.
package sync_tx_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } tx_state_t;

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_tx_fifo_mem.sv
// Circular buffer for the tx feeder: pointers, registered level/full and a
// sticky overflow flag. Reads are combinational from the head entry.
module sync_tx_fifo_mem
    import sync_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = addr_bits(DEPTH)
) (
    input  logic                  clk_tx,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_next;
    logic                  push;
    logic                  pop;

    // A push against a full buffer is dropped even if a pop frees a slot
    // on the same edge; the decision uses the registered level only.
    assign push = wr_en && (level != FULL_LEVEL);
    assign pop  = rd_en && (level != '0);

    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LVL_ONE;
        end else if (!push && pop) begin
            level_next = level - LVL_ONE;
        end
    end

    always_ff @(posedge clk_tx) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_next;
            full  <= (level_next == FULL_LEVEL);
            if (wr_en && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_tx_fifo.sv
// Tx feeder: buffers core words and presents them one at a time to
// sync_multi using a 4-phase req (tx_v) / ack (tx_f) handshake.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | no request; pop head word when FIFO non-empty and ack low
//   ST_REQ     | tx_v high, tx_data stable; wait for ack high
//   ST_RELEASE | tx_v low, tx_data held; wait for ack low, count transfer
module sync_tx_fifo
    import sync_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = addr_bits(DEPTH),
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk_tx,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_v,
    input  logic                  tx_f,
    output logic [CNT_WIDTH-1:0]  sent_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    tx_state_t             state;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    // A still-high ack from the previous word blocks the next pop, so a
    // new request is never raised into a stale acknowledge.
    assign pop = (state == ST_IDLE) && (wr_level != '0) && !tx_f;

    sync_tx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_tx   (clk_tx),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (wr_full),
        .level    (wr_level),
        .overflow (overflow)
    );

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tx_data  <= '0;
            tx_v     <= 1'b0;
            sent_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data <= head;
                        tx_v    <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tx_f) begin
                        tx_v  <= 1'b0;
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!tx_f) begin
                        sent_cnt <= sent_cnt + CNT_ONE;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    tx_v  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_tx_fifo.sv
// Self-checking bench for sync_tx_fifo: queue-based reference model, per-cycle
// compare of all outputs, plus directed scenarios with literal expectations.
module tb_sync_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 8;

    logic          clk_tx = 1'b0;
    logic          reset  = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en   = 1'b0;
    logic          wr_full;
    logic [AW:0]   wr_level;
    logic          overflow;
    logic [DW-1:0] tx_data;
    logic          tx_v;
    logic          tx_f = 1'b0;
    logic [CW-1:0] sent_cnt;

    sync_tx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_tx   (clk_tx),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .wr_full  (wr_full),
        .wr_level (wr_level),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_v     (tx_v),
        .tx_f     (tx_f),
        .sent_cnt (sent_cnt)
    );

    always #5 clk_tx = ~clk_tx;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue contents, word on the wire, handshake phase
    // (0 = no word outstanding, 1 = request raised, 2 = waiting for ack drop).
    logic [DW-1:0] mq[$];
    logic [DW-1:0] delivered[$];
    logic [DW-1:0] m_data = '0;
    logic          m_v    = 1'b0;
    logic          m_ovf  = 1'b0;
    int            m_phase = 0;
    int            m_cnt   = 0;
    int            m_sz;
    bit            m_push;

    initial forever begin
        @(posedge clk_tx or negedge reset);
        if (!reset) begin
            mq.delete();
            m_data = '0; m_v = 1'b0; m_ovf = 1'b0; m_phase = 0; m_cnt = 0;
        end else begin
            m_sz   = mq.size();
            m_push = wr_en && (m_sz < DEPTH);
            if (wr_en && !m_push) m_ovf = 1'b1;
            if (m_phase == 0 && m_sz > 0 && !tx_f) begin
                m_data = mq.pop_front();
                delivered.push_back(m_data);
                m_v = 1'b1;
                m_phase = 1;
            end else if (m_phase == 1 && tx_f) begin
                m_v = 1'b0;
                m_phase = 2;
            end else if (m_phase == 2 && !tx_f) begin
                m_cnt++;
                m_phase = 0;
            end
            if (m_push) mq.push_back(wr_data);
        end
    end

    initial forever begin
        @(negedge clk_tx);
        check("tx_v", 32'(tx_v), 32'(m_v));
        check("tx_data", 32'(tx_data), 32'(m_data));
        check("wr_level", 32'(wr_level), 32'(mq.size()));
        check("wr_full", 32'(wr_full), 32'(mq.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("sent_cnt", 32'(sent_cnt), 32'(m_cnt % 256));
    end

    // Acknowledge source: tx_v delayed by ack_delay cycles, or a forced level.
    bit       ack_auto  = 1'b1;
    bit       ack_force = 1'b0;
    int       ack_delay = 3;
    logic [7:0] hist    = '0;

    initial forever begin
        @(posedge clk_tx);
        #2;
        hist = {hist[6:0], tx_v};
        if (ack_auto) tx_f = hist[ack_delay-1];
        else          tx_f = ack_force;
    end

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((mq.size() != 0 || m_phase != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: still busy after %0d cycles, expected idle", budget);
        end
        tick();
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        logic [DW-1:0] burst [4];
        burst[0] = 8'h35; burst[1] = 8'hFF; burst[2] = 8'h0F; burst[3] = 8'hC3;

        #2 reset = 1'b0;
        #1;
        check("rst_tx_v", 32'(tx_v), 32'd0);
        check("rst_wr_level", 32'(wr_level), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // single word
        delivered.delete();
        ack_auto = 1'b1; ack_delay = 3;
        push(8'hA5);
        check("single_level_after_push", 32'(wr_level), 32'd1);
        check("single_v_after_push", 32'(tx_v), 32'd0);
        tick();
        check("single_v", 32'(tx_v), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_level_popped", 32'(wr_level), 32'd0);
        drain(50);
        check("single_cnt", 32'(sent_cnt), 32'd1);
        check("single_model_word", 32'(delivered[0]), 32'hA5);

        // burst of four on consecutive cycles
        delivered.delete();
        ack_delay = 4;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = burst[i];
            tick();
        end
        wr_en = 1'b0;
        drain(200);
        check("burst_cnt", 32'(sent_cnt), 32'd5);
        check("burst_n", 32'(delivered.size()), 32'd4);
        for (int i = 0; i < 4 && i < delivered.size(); i++)
            check("burst_word", 32'(delivered[i]), 32'(burst[i]));

        // overflow: ack held low, six consecutive pushes
        delivered.delete();
        ack_auto = 1'b0; ack_force = 1'b0;
        tick();
        for (int i = 1; i <= 6; i++) push(8'(i));
        check("ovf_level", 32'(wr_level), 32'd4);
        check("ovf_full", 32'(wr_full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_inflight", 32'(tx_data), 32'h01);
        check("ovf_v", 32'(tx_v), 32'd1);
        hist = '0; ack_delay = 2; ack_auto = 1'b1;
        drain(200);
        check("ovf_n", 32'(delivered.size()), 32'd5);
        for (int i = 0; i < 5 && i < delivered.size(); i++)
            check("ovf_word", 32'(delivered[i]), 32'(i + 1));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // stale ack held high while words wait
        ack_auto = 1'b0; ack_force = 1'b1;
        tick();
        push(8'h11);
        push(8'h22);
        tick();
        check("stale_level", 32'(wr_level), 32'd2);
        check("stale_v", 32'(tx_v), 32'd0);
        ack_force = 1'b0;
        tick();
        tick();
        check("stale_issue_v", 32'(tx_v), 32'd1);
        check("stale_issue_data", 32'(tx_data), 32'h11);
        check("stale_issue_level", 32'(wr_level), 32'd1);
        hist = '0; ack_auto = 1'b1;
        drain(200);

        // reset in the middle of a handshake
        ack_auto = 1'b0; ack_force = 1'b0;
        tick();
        push(8'h35);
        push(8'h46);
        push(8'h57);
        check("pre_rst_v", 32'(tx_v), 32'd1);
        check("pre_rst_data", 32'(tx_data), 32'h35);
        check("pre_rst_level", 32'(wr_level), 32'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_v", 32'(tx_v), 32'd0);
        check("mid_rst_data", 32'(tx_data), 32'd0);
        check("mid_rst_level", 32'(wr_level), 32'd0);
        check("mid_rst_cnt", 32'(sent_cnt), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("post_rst_v", 32'(tx_v), 32'd0);

        // randomized traffic at two ack latencies
        hist = '0; ack_auto = 1'b1;
        for (int seg = 0; seg < 2; seg++) begin
            ack_delay = (seg == 0) ? 1 : 5;
            for (int c = 0; c < 400; c++) begin
                wr_en = ($urandom_range(0, 2) == 0);
                wr_data = 8'($urandom);
                tick();
            end
            wr_en = 1'b0;
            drain(400);
        end

        // counter wrap over 256 transfers
        pulse_reset();
        hist = '0; ack_delay = 1;
        delivered.delete();
        for (int i = 0; i < 256; i++) begin
            push(8'($urandom));
            drain(60);
        end
        check("wrap_cnt", 32'(sent_cnt), 32'd0);
        check("wrap_model_cnt", 32'(m_cnt), 32'd256);
        check("wrap_delivered", 32'(delivered.size()), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
